// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-enable write port, 1/2-cycle registered read,
// selectable read-during-write behaviour and an optional post-reset zero-fill.
module ram_sdp_be #(
  parameter int unsigned CAddrLen  = 10,
  parameter int unsigned CDataLen  = 128,
  parameter int unsigned CRdLat    = 1,
  parameter int unsigned CRdwMode  = 0,
  parameter int unsigned CInitZero = 1
) (
  input  logic                  AClkH,
  input  logic                  AResetH,
  input  logic                  AClkHEn,
  input  logic [CAddrLen-1:0]   AAddrWr,
  input  logic [CDataLen-1:0]   AMosi,
  input  logic                  AWrEn,
  input  logic [CDataLen/8-1:0] AWrBe,
  input  logic [CAddrLen-1:0]   AAddrRd,
  input  logic                  ARdEn,
  output logic [CDataLen-1:0]   AMiso,
  output logic                  ARdVld,
  output logic                  ABusy
);

  localparam int unsigned CDepth = 2 ** CAddrLen;
  localparam int unsigned CBytes = CDataLen / 8;

  if (!(CRdLat == 1 || CRdLat == 2)) begin : g_err_lat
    $error("ram_sdp_be: CRdLat must be 1 or 2");
  end
  if ((CDataLen % 8) != 0) begin : g_err_width
    $error("ram_sdp_be: CDataLen must be a multiple of 8");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CAddrLen-1:0]   r_cnt;
  logic [CAddrLen-1:0]   w_cnt_nxt;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  logic [CDataLen-1:0]   r_mem [CDepth];
  logic [CDataLen-1:0]   w_rd_old;
  logic [CDataLen-1:0]   w_rd_merge;
  logic [CDataLen-1:0]   w_rd_word;

  logic                  r_p1_vld;
  logic [CDataLen-1:0]   r_p1_data;
  logic                  r_p2_vld;
  logic [CDataLen-1:0]   r_p2_data;

  // State and fill-counter register; a held clock enable freezes both.
  always_ff @(posedge AClkH) begin
    if (AClkHEn) begin
      if (AResetH) begin
        r_state <= (CInitZero != 0) ? CLEAR : IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end
  end

  // Next state, fill counter and user-strobe acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_acc    = 1'b0;
    w_wr_acc    = 1'b0;
    case (r_state)
      CLEAR: begin
        w_cnt_nxt = r_cnt + CAddrLen'(1);
        if (&r_cnt) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_rd_acc = ARdEn;
        w_wr_acc = AWrEn;
      end
    endcase
  end

  // Read word selection; same-address merge only matters in new-data mode.
  always_comb begin
    w_rd_old   = r_mem[AAddrRd];
    w_rd_merge = w_rd_old;
    for (int unsigned i = 0; i < CBytes; i++) begin
      if (AWrBe[i]) begin
        w_rd_merge[8*i +: 8] = AMosi[8*i +: 8];
      end
    end
    w_rd_word = w_rd_old;
    if ((CRdwMode != 0) && w_wr_acc && (AAddrWr == AAddrRd)) begin
      w_rd_word = w_rd_merge;
    end
  end

  // Array: zero-fill word per cycle while clearing, byte-masked user write otherwise.
  always_ff @(posedge AClkH) begin
    if (AClkHEn && !AResetH) begin
      if (r_state == CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else if (w_wr_acc) begin
        for (int unsigned i = 0; i < CBytes; i++) begin
          if (AWrBe[i]) begin
            r_mem[AAddrWr][8*i +: 8] <= AMosi[8*i +: 8];
          end
        end
      end
    end
  end

  // Read pipeline; data is zeroed whenever its valid is low so AMiso never shows X.
  always_ff @(posedge AClkH) begin
    if (AClkHEn) begin
      if (AResetH) begin
        r_p1_vld  <= 1'b0;
        r_p1_data <= '0;
        r_p2_vld  <= 1'b0;
        r_p2_data <= '0;
      end else begin
        r_p1_vld  <= w_rd_acc;
        r_p1_data <= w_rd_acc ? w_rd_word : '0;
        r_p2_vld  <= r_p1_vld;
        r_p2_data <= r_p1_data;
      end
    end
  end

  assign ARdVld = (CRdLat == 2) ? r_p2_vld  : r_p1_vld;
  assign AMiso  = (CRdLat == 2) ? r_p2_data : r_p1_data;
  assign ABusy  = (r_state == CLEAR);

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances (1-cycle/old-data and 2-cycle/new-data) share stimulus;
// a reference memory feeds per-instance expected-read queues checked every cycle.
module tb_ram_sdp_be;

  logic         clk;
  logic         rst, en, we, re;
  logic [3:0]   wa, ra;
  logic [127:0] wd;
  logic [15:0]  be;
  logic [127:0] miso_a, miso_b;
  logic         vld_a, vld_b, busy_a, busy_b;

  ram_sdp_be #(.CAddrLen(4), .CDataLen(128), .CRdLat(1), .CRdwMode(0), .CInitZero(1)) u_a (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en), .AAddrWr(wa), .AMosi(wd), .AWrEn(we),
    .AWrBe(be), .AAddrRd(ra), .ARdEn(re), .AMiso(miso_a), .ARdVld(vld_a), .ABusy(busy_a));

  ram_sdp_be #(.CAddrLen(4), .CDataLen(128), .CRdLat(2), .CRdwMode(1), .CInitZero(1)) u_b (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en), .AAddrWr(wa), .AMosi(wd), .AWrEn(we),
    .AWrBe(be), .AAddrRd(ra), .ARdEn(re), .AMiso(miso_b), .ARdVld(vld_b), .ABusy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    logic         we;
    logic [3:0]   wa;
    logic [127:0] wd;
    logic [15:0]  be;
    logic         re;
    logic [3:0]   ra;
    logic [127:0] ea;
    logic [127:0] eb;
  } vec_t;

  exp_t         qa[$];
  exp_t         qb[$];
  logic [127:0] m_mem [16];
  int           m_fill  = 0;
  int           en_edges = 0;
  bit           mon_on  = 0;
  int           n_vec   = 0;
  int           n_err   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, then advance the reference model.
  task automatic step(input logic s_en, input logic s_rst, input logic s_we, input logic [3:0] s_wa,
                      input logic [127:0] s_wd, input logic [15:0] s_be, input logic s_re,
                      input logic [3:0] s_ra, input bit tab, input logic [127:0] ea,
                      input logic [127:0] eb);
    logic [127:0] old, mrg;
    en = s_en; rst = s_rst; we = s_we; wa = s_wa; wd = s_wd; be = s_be; re = s_re; ra = s_ra;
    @(posedge clk);
    #1;
    if (s_en) begin
      en_edges++;
      if (s_rst) begin
        m_fill = 16;
        qa.delete();
        qb.delete();
        mon_on = 1;
      end else if (m_fill > 0) begin
        m_mem[16 - m_fill] = '0;
        m_fill--;
      end else begin
        if (s_re) begin
          old = m_mem[s_ra];
          mrg = old;
          if (s_we && s_wa == s_ra)
            for (int i = 0; i < 16; i++) if (s_be[i]) mrg[8*i +: 8] = s_wd[8*i +: 8];
          qa.push_back('{en_edges, tab ? ea : old});
          qb.push_back('{en_edges + 1, tab ? eb : mrg});
        end
        if (s_we)
          for (int i = 0; i < 16; i++) if (s_be[i]) m_mem[s_wa][8*i +: 8] = s_wd[8*i +: 8];
      end
    end
  endtask

  task automatic idle(input logic s_en);
    step(s_en, 1'b0, 1'b0, 4'd0, '0, '0, 1'b0, 4'd0, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b1, 1'b0, 1'b0, 4'd0, '0, '0, 1'b1, a, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [127:0] d, input logic [15:0] m);
    step(1'b1, 1'b0, 1'b1, a, d, m, 1'b0, 4'd0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 4'd0, '0, '0, 1'b0, 4'd0, 1'b0, '0, '0);
  endtask

  // Output monitor: retire stale expectations, then compare valid/data/busy each cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      while (qa.size() > 0 && qa[0].due < en_edges) void'(qa.pop_front());
      while (qb.size() > 0 && qb[0].due < en_edges) void'(qb.pop_front());
      if (qa.size() > 0 && qa[0].due == en_edges) begin
        chk("a_vld", 128'(vld_a), 128'(1));
        chk("a_data", miso_a, qa[0].data);
      end else begin
        chk("a_idle", {miso_a[126:0], vld_a}, '0);
      end
      if (qb.size() > 0 && qb[0].due == en_edges) begin
        chk("b_vld", 128'(vld_b), 128'(1));
        chk("b_data", miso_b, qb[0].data);
      end else begin
        chk("b_idle", {miso_b[126:0], vld_b}, '0);
      end
      chk("busy_a", 128'(busy_a), 128'(m_fill > 0));
      chk("busy_b", 128'(busy_b), 128'(m_fill > 0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  vec_t tab[12];
  int   n;

  initial begin
    tab[0]  = '{1'b1, 4'd3, {16{8'hFF}}, 16'hFFFF, 1'b0, 4'd0, '0, '0};
    tab[1]  = '{1'b1, 4'd3, {16{8'hAB}}, 16'h0001, 1'b0, 4'd0, '0, '0};
    tab[2]  = '{1'b0, 4'd0, '0, 16'h0000, 1'b1, 4'd3, {{15{8'hFF}}, 8'hAB}, {{15{8'hFF}}, 8'hAB}};
    tab[3]  = '{1'b1, 4'd7, {16{8'h11}}, 16'hFFFF, 1'b0, 4'd0, '0, '0};
    tab[4]  = '{1'b1, 4'd7, {16{8'h55}}, 16'h00FF, 1'b1, 4'd7, {16{8'h11}},
                {{8{8'h11}}, {8{8'h55}}}};
    tab[5]  = '{1'b0, 4'd0, '0, 16'h0000, 1'b1, 4'd7, {{8{8'h11}}, {8{8'h55}}},
                {{8{8'h11}}, {8{8'h55}}}};
    tab[6]  = '{1'b1, 4'd5, {16{8'hC3}}, 16'h8001, 1'b1, 4'd3, {{15{8'hFF}}, 8'hAB},
                {{15{8'hFF}}, 8'hAB}};
    tab[7]  = '{1'b0, 4'd0, '0, 16'h0000, 1'b1, 4'd5, {8'hC3, {14{8'h00}}, 8'hC3},
                {8'hC3, {14{8'h00}}, 8'hC3}};
    tab[8]  = '{1'b1, 4'd3, '0, 16'hFFFF, 1'b1, 4'd3, {{15{8'hFF}}, 8'hAB}, '0};
    tab[9]  = '{1'b0, 4'd0, '0, 16'h0000, 1'b1, 4'd3, '0, '0};
    tab[10] = '{1'b1, 4'd9, {16{8'hFF}}, 16'h0000, 1'b1, 4'd9, '0, '0};
    tab[11] = '{1'b0, 4'd0, '0, 16'h0000, 1'b1, 4'd9, '0, '0};

    en = 0; rst = 0; we = 0; re = 0; wa = '0; ra = '0; wd = '0; be = '0;

    // Zero-fill after reset, then every word reads back zero.
    do_reset();
    n = 0;
    for (int k = 0; k < 40 && busy_a; k++) begin idle(1'b1); n++; end
    chk("fill_len", 128'(n), 128'(16));
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(1'b1); idle(1'b1);

    // Byte-enable writes and read-during-write from the vector table.
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b0, tab[i].we, tab[i].wa, tab[i].wd, tab[i].be, tab[i].re, tab[i].ra,
           1'b1, tab[i].ea, tab[i].eb);
    idle(1'b1); idle(1'b1);

    // Back-to-back reads at full throughput.
    for (int a = 0; a < 8; a++) wr(4'(a), {16{8'(a * 17 + 1)}}, 16'hFFFF);
    for (int a = 0; a < 8; a++) rd(4'(a));
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Clock enable dropped mid-fill: fill still totals 16 enabled cycles.
    do_reset();
    n = 0;
    for (int k = 0; k < 5; k++) begin idle(1'b1); n++; end
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 1'b1, 4'd2, {16{8'hEE}}, 16'hFFFF, 1'b1, 4'd2, 1'b0, '0, '0);
    for (int k = 0; k < 40 && busy_a; k++) begin idle(1'b1); n++; end
    chk("fill_len_gated", 128'(n), 128'(16));

    // Clock enable dropped mid-read: outputs hold, frozen strobes have no effect.
    wr(4'd0, {16{8'hA5}}, 16'hFFFF);
    rd(4'd0);
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 1'b1, 4'd0, {16{8'hFF}}, 16'hFFFF, 1'b1, 4'd1, 1'b0, '0, '0);
    idle(1'b1); idle(1'b1);
    rd(4'd0);
    idle(1'b1); idle(1'b1);

    // Reset at fill counter 9 restarts the fill; writes during fill are dropped.
    do_reset();
    for (int k = 0; k < 9; k++) idle(1'b1);
    do_reset();
    n = 0;
    for (int k = 0; k < 40 && busy_a; k++) begin
      if (k == 5) step(1'b1, 1'b0, 1'b1, 4'd2, {16{8'h77}}, 16'hFFFF, 1'b1, 4'd2, 1'b0, '0, '0);
      else idle(1'b1);
      n++;
    end
    chk("fill_len_restart", 128'(n), 128'(16));
    rd(4'd2);
    rd(4'd9);
    idle(1'b1); idle(1'b1); idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
